// File: rtl/cpu_run_harness.sv
// Load/run/check harness for the 16-bit CPU: copies a program and a data preload from an
// image ROM, runs the CPU until halt or timeout, then compares a list of registers.
module cpu_run_harness #(
    parameter int PROG_LEN   = 32,
    parameter int DPRE_LEN   = 2,
    parameter int NUM_CHECKS = 2,
    parameter int DATA_W     = 16,
    parameter int IMG_AW     = 8,
    parameter int RA_W       = 4,
    parameter int TIMEOUT    = 4096,
    localparam int CIW       = $clog2(NUM_CHECKS) + 1,
    localparam int CW        = $clog2(TIMEOUT + 1)
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              start,
    output logic [IMG_AW-1:0] img_addr,
    input  logic [DATA_W-1:0] img_data,
    output logic              imem_we,
    output logic [IMG_AW-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              cpu_rst,
    input  logic              do_halt,
    output logic [CIW-1:0]    chk_idx,
    input  logic [RA_W-1:0]   chk_reg,
    input  logic [DATA_W-1:0] chk_exp,
    output logic [RA_W-1:0]   reg_raddr,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              res_valid,
    output logic [CIW-1:0]    res_idx,
    output logic [DATA_W-1:0] res_data,
    output logic              res_ok,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [CW-1:0]     cycle_count
);

    localparam int SW = IMG_AW + 1;
    localparam logic [SW-1:0]     PL       = SW'(PROG_LEN);
    localparam logic [SW-1:0]     DL2      = SW'(2 * DPRE_LEN);
    localparam logic [IMG_AW-1:0] DPRE_BASE = (DPRE_LEN > 0) ? IMG_AW'(PROG_LEN) : '0;
    localparam logic [CIW-1:0]    LAST_CHK = CIW'(NUM_CHECKS - 1);
    localparam logic [CW-1:0]     TO_LIM   = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_I, S_LOAD_D, S_RUN, S_CHECK, S_DONE
    } state_t;

    state_t            state_reg;
    logic [SW-1:0]     step_reg;
    logic              halt_prev_reg;
    logic              issue_reg;
    logic [DATA_W-1:0] exp_reg;
    logic [CIW-1:0]    mism_reg;

    logic           halt_evt;
    logic           match;
    logic [CIW-1:0] mism_next;

    assign halt_evt  = halt_prev_reg && !do_halt;
    assign match     = (reg_rdata == exp_reg);
    assign mism_next = mism_reg + CIW'(res_valid && !match);

    // ROM and register-file data arrive one cycle after their address, so the
    // write data and check results pass straight through, gated by their strobes.
    assign imem_wdata = imem_we ? img_data : '0;
    assign dmem_wdata = dmem_we ? img_data : '0;
    assign reg_raddr  = issue_reg ? chk_reg : '0;
    assign res_data   = res_valid ? reg_rdata : '0;
    assign res_ok     = res_valid && match;
    assign busy       = (state_reg == S_LOAD_I) || (state_reg == S_LOAD_D) ||
                        (state_reg == S_RUN)    || (state_reg == S_CHECK);

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_reg     <= S_IDLE;
            step_reg      <= '0;
            halt_prev_reg <= 1'b0;
            issue_reg     <= 1'b0;
            exp_reg       <= '0;
            mism_reg      <= '0;
            img_addr      <= '0;
            imem_we       <= 1'b0;
            imem_addr     <= '0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            cpu_rst       <= 1'b0;
            chk_idx       <= '0;
            res_valid     <= 1'b0;
            res_idx       <= '0;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            cycle_count   <= '0;
        end else begin
            imem_we   <= 1'b0;
            imem_addr <= '0;
            dmem_we   <= 1'b0;
            dmem_addr <= '0;
            res_valid <= 1'b0;
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_reg   <= S_LOAD_I;
                        step_reg    <= '0;
                        img_addr    <= '0;
                        cycle_count <= '0;
                        mism_reg    <= '0;
                        pass        <= 1'b0;
                        timeout     <= 1'b0;
                        done        <= 1'b0;
                    end
                end
                S_LOAD_I: begin
                    if (step_reg == PL) begin
                        state_reg <= S_LOAD_D;
                        step_reg  <= '0;
                        img_addr  <= DPRE_BASE;
                    end else begin
                        imem_we   <= 1'b1;
                        imem_addr <= img_addr;
                        step_reg  <= step_reg + 1'b1;
                        if (step_reg + 1'b1 < PL)
                            img_addr <= img_addr + 1'b1;
                    end
                end
                S_LOAD_D: begin
                    // Odd steps deliver an address word; the data word follows next cycle.
                    if (step_reg[0]) begin
                        dmem_we   <= 1'b1;
                        dmem_addr <= img_data;
                    end
                    if (step_reg == DL2) begin
                        state_reg     <= S_RUN;
                        cpu_rst       <= 1'b1;
                        halt_prev_reg <= 1'b0;
                        img_addr      <= '0;
                    end else begin
                        step_reg <= step_reg + 1'b1;
                        img_addr <= img_addr + 1'b1;
                    end
                end
                S_RUN: begin
                    halt_prev_reg <= do_halt;
                    cycle_count   <= cycle_count + 1'b1;
                    // Halt wins when it coincides with the timeout limit.
                    if (halt_evt) begin
                        cpu_rst   <= 1'b0;
                        state_reg <= S_CHECK;
                        chk_idx   <= '0;
                        issue_reg <= 1'b1;
                    end else if (cycle_count + 1'b1 == TO_LIM) begin
                        cpu_rst   <= 1'b0;
                        timeout   <= 1'b1;
                        pass      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= S_DONE;
                    end
                end
                S_CHECK: begin
                    mism_reg <= mism_next;
                    if (issue_reg) begin
                        res_valid <= 1'b1;
                        res_idx   <= chk_idx;
                        exp_reg   <= chk_exp;
                        chk_idx   <= chk_idx + 1'b1;
                        if (chk_idx == LAST_CHK)
                            issue_reg <= 1'b0;
                    end else begin
                        state_reg <= S_DONE;
                        done      <= 1'b1;
                        pass      <= (mism_next == '0);
                        chk_idx   <= '0;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_harness.sv
// Directed bench for cpu_run_harness: ROM, register file and a stub CPU whose halt
// timing is programmable, with two harness configurations.
module tb_cpu_run_harness;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   vecs = 0;
    int   errs = 0;
    int   halt_lo, halt_hi;

    logic [15:0] rom  [256];
    logic [15:0] regs [16];
    logic [3:0]  r_tab [2];
    logic [15:0] e_tab [2];

    // ---------------- instance A: full configuration ----------------
    logic        start_a, imem_we_a, dmem_we_a, cpu_rst_a, do_halt_a;
    logic [7:0]  img_addr_a, imem_addr_a;
    logic [15:0] img_data_a, imem_wdata_a, dmem_addr_a, dmem_wdata_a;
    logic [1:0]  chk_idx_a, res_idx_a;
    logic [3:0]  chk_reg_a, reg_raddr_a;
    logic [15:0] chk_exp_a, reg_rdata_a, res_data_a;
    logic        res_valid_a, res_ok_a, busy_a, done_a, pass_a, timeout_a;
    logic [6:0]  cycle_count_a;
    logic [15:0] cyc_a;

    cpu_run_harness #(.PROG_LEN(32), .DPRE_LEN(2), .NUM_CHECKS(2), .DATA_W(16),
                      .IMG_AW(8), .RA_W(4), .TIMEOUT(64)) u_dut_a (
        .CLK(clk), .rst(rst), .start(start_a),
        .img_addr(img_addr_a), .img_data(img_data_a),
        .imem_we(imem_we_a), .imem_addr(imem_addr_a), .imem_wdata(imem_wdata_a),
        .dmem_we(dmem_we_a), .dmem_addr(dmem_addr_a), .dmem_wdata(dmem_wdata_a),
        .cpu_rst(cpu_rst_a), .do_halt(do_halt_a),
        .chk_idx(chk_idx_a), .chk_reg(chk_reg_a), .chk_exp(chk_exp_a),
        .reg_raddr(reg_raddr_a), .reg_rdata(reg_rdata_a),
        .res_valid(res_valid_a), .res_idx(res_idx_a), .res_data(res_data_a), .res_ok(res_ok_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .timeout(timeout_a),
        .cycle_count(cycle_count_a));

    always @(posedge clk) img_data_a  <= rom[img_addr_a];
    always @(posedge clk) reg_rdata_a <= regs[reg_raddr_a];
    always @(posedge clk) cyc_a <= cpu_rst_a ? cyc_a + 16'd1 : 16'd0;
    assign do_halt_a = cpu_rst_a && (int'(cyc_a) >= halt_lo) && (int'(cyc_a) <= halt_hi);
    assign chk_reg_a = r_tab[chk_idx_a[0]];
    assign chk_exp_a = e_tab[chk_idx_a[0]];

    // ---------------- instance B: no preload, one check ----------------
    logic        start_b, imem_we_b, dmem_we_b, cpu_rst_b, do_halt_b;
    logic [7:0]  img_addr_b, imem_addr_b;
    logic [15:0] img_data_b, imem_wdata_b, dmem_addr_b, dmem_wdata_b;
    logic        chk_idx_b, res_idx_b;
    logic [3:0]  chk_reg_b, reg_raddr_b;
    logic [15:0] chk_exp_b, reg_rdata_b, res_data_b;
    logic        res_valid_b, res_ok_b, busy_b, done_b, pass_b, timeout_b;
    logic [6:0]  cycle_count_b;
    logic [15:0] cyc_b;

    cpu_run_harness #(.PROG_LEN(4), .DPRE_LEN(0), .NUM_CHECKS(1), .DATA_W(16),
                      .IMG_AW(8), .RA_W(4), .TIMEOUT(64)) u_dut_b (
        .CLK(clk), .rst(rst), .start(start_b),
        .img_addr(img_addr_b), .img_data(img_data_b),
        .imem_we(imem_we_b), .imem_addr(imem_addr_b), .imem_wdata(imem_wdata_b),
        .dmem_we(dmem_we_b), .dmem_addr(dmem_addr_b), .dmem_wdata(dmem_wdata_b),
        .cpu_rst(cpu_rst_b), .do_halt(do_halt_b),
        .chk_idx(chk_idx_b), .chk_reg(chk_reg_b), .chk_exp(chk_exp_b),
        .reg_raddr(reg_raddr_b), .reg_rdata(reg_rdata_b),
        .res_valid(res_valid_b), .res_idx(res_idx_b), .res_data(res_data_b), .res_ok(res_ok_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .timeout(timeout_b),
        .cycle_count(cycle_count_b));

    always @(posedge clk) img_data_b  <= rom[img_addr_b];
    always @(posedge clk) reg_rdata_b <= regs[reg_raddr_b];
    always @(posedge clk) cyc_b <= cpu_rst_b ? cyc_b + 16'd1 : 16'd0;
    assign do_halt_b = cpu_rst_b && (int'(cyc_b) >= halt_lo) && (int'(cyc_b) <= halt_hi);
    assign chk_reg_b = r_tab[chk_idx_b];
    assign chk_exp_b = e_tab[chk_idx_b];

    // ---------------- monitors (sampled on the falling edge) ----------------
    logic [15:0] imem_m [256];
    logic [15:0] dmem_m [256];
    int          wr_a, dwr_a, busy_n_a, res_n_a, wr_b, dwr_b, busy_n_b, res_n_b;
    logic [1:0]  r_idx [4];
    logic [15:0] r_data [4];
    logic        r_ok [4];
    logic        rb_ok;
    logic        rb_idx;

    always @(negedge clk) begin
        if (imem_we_a) begin imem_m[imem_addr_a] = imem_wdata_a; wr_a++; end
        if (dmem_we_a) begin dmem_m[dmem_addr_a[7:0]] = dmem_wdata_a; wr_a++; dwr_a++; end
        if (busy_a) busy_n_a++;
        if (res_valid_a) begin
            if (res_n_a < 4) begin
                r_idx[res_n_a] = res_idx_a; r_data[res_n_a] = res_data_a; r_ok[res_n_a] = res_ok_a;
            end
            res_n_a++;
        end
        if (imem_we_b) wr_b++;
        if (dmem_we_b) dwr_b++;
        if (busy_b) busy_n_b++;
        if (res_valid_b) begin rb_ok = res_ok_b; rb_idx = res_idx_b; res_n_b++; end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic outs_a_nonzero();
        return |{img_addr_a, imem_we_a, imem_addr_a, imem_wdata_a, dmem_we_a, dmem_addr_a,
                 dmem_wdata_a, cpu_rst_a, chk_idx_a, reg_raddr_a, res_valid_a, res_idx_a,
                 res_data_a, res_ok_a, busy_a, done_a, pass_a, timeout_a, cycle_count_a};
    endfunction

    task automatic clear_counts();
        @(posedge clk); #1;
        wr_a = 0; dwr_a = 0; busy_n_a = 0; res_n_a = 0;
        wr_b = 0; dwr_b = 0; busy_n_b = 0; res_n_b = 0;
    endtask

    task automatic pulse_a();
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
    endtask

    task automatic wait_done_a(input string tag);
        for (int i = 0; i < 400; i++) begin
            if (done_a) break;
            @(negedge clk);
        end
        chk(tag, 32'(done_a), 32'd1);
    endtask

    task automatic run_a(input string tag);
        clear_counts();
        pulse_a();
        wait_done_a(tag);
    endtask

    task automatic check_good_run(input string tag, input int cyc);
        $display("%s: busy=%0d writes=%0d res=%0d cycles=%0d pass=%0d", tag,
                 busy_n_a, wr_a, res_n_a, cycle_count_a, pass_a);
        chk({tag, "_writes"}, 32'(wr_a), 32'd34);
        chk({tag, "_busy"}, 32'(busy_n_a), 32'(38 + cyc + 3));
        chk({tag, "_nres"}, 32'(res_n_a), 32'd2);
        chk({tag, "_cycles"}, 32'(cycle_count_a), 32'(cyc));
        chk({tag, "_pass"}, 32'(pass_a), 32'd1);
        chk({tag, "_timeout"}, 32'(timeout_a), 32'd0);
    endtask

    initial begin
        int good;
        for (int i = 0; i < 256; i++) rom[i] = 16'h1000 + 16'(i * 7);
        rom[32] = 16'd50; rom[33] = 16'd1; rom[34] = 16'd51; rom[35] = 16'd100;
        for (int i = 0; i < 16; i++) regs[i] = 16'(i * 11);
        regs[10] = 16'd624; regs[7] = 16'd7;
        r_tab[0] = 4'd10; e_tab[0] = 16'd624;
        r_tab[1] = 4'd7;  e_tab[1] = 16'd7;
        halt_lo = 30; halt_hi = 30;
        start_a = 1'b0; start_b = 1'b0;
        rst = 1'b1;
        #3 rst = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_outs_a", 32'(outs_a_nonzero()), 32'd0);
        chk("rst_cpu_rst_b", 32'(cpu_rst_b), 32'd0);
        @(negedge clk); rst = 1'b1;

        // Full program: halt pulse at RUN cycle 30 -> falling edge seen at cycle 31 -> 32 cycles
        run_a("full_done");
        check_good_run("full", 32);
        good = 0;
        for (int i = 0; i < 32; i++) if (imem_m[i] === 16'h1000 + 16'(i * 7)) good++;
        chk("full_imem_image", 32'(good), 32'd32);
        chk("full_dmem50", 32'(dmem_m[50]), 32'd1);
        chk("full_dmem51", 32'(dmem_m[51]), 32'd100);
        chk("full_res0_idx", 32'(r_idx[0]), 32'd0);
        chk("full_res0_data", 32'(r_data[0]), 32'd624);
        chk("full_res0_ok", 32'(r_ok[0]), 32'd1);
        chk("full_res1_idx", 32'(r_idx[1]), 32'd1);
        chk("full_res1_data", 32'(r_data[1]), 32'd7);
        chk("full_res1_ok", 32'(r_ok[1]), 32'd1);
        chk("full_cpu_rst", 32'(cpu_rst_a), 32'd0);
        chk("full_busy", 32'(busy_a), 32'd0);

        // Mismatch on check 0
        e_tab[0] = 16'd625;
        run_a("mis_done");
        $display("mismatch: res0 ok=%0d data=%0d res1 ok=%0d pass=%0d", r_ok[0], r_data[0], r_ok[1], pass_a);
        chk("mis_res0_ok", 32'(r_ok[0]), 32'd0);
        chk("mis_res0_data", 32'(r_data[0]), 32'd624);
        chk("mis_res1_ok", 32'(r_ok[1]), 32'd1);
        chk("mis_pass", 32'(pass_a), 32'd0);
        e_tab[0] = 16'd624;

        // start pulses during LOAD_I and RUN are ignored
        clear_counts();
        pulse_a();
        repeat (5) @(negedge clk);
        pulse_a();
        for (int i = 0; i < 200; i++) begin
            if (cpu_rst_a) break;
            @(negedge clk);
        end
        chk("ign_run_reached", 32'(cpu_rst_a), 32'd1);
        repeat (3) @(negedge clk);
        pulse_a();
        wait_done_a("ign_done");
        check_good_run("ignore", 32);

        // Timeout: CPU never halts
        halt_lo = 1000; halt_hi = 1000;
        run_a("to_done");
        $display("timeout: busy=%0d res=%0d cycles=%0d timeout=%0d", busy_n_a, res_n_a, cycle_count_a, timeout_a);
        chk("to_flag", 32'(timeout_a), 32'd1);
        chk("to_pass", 32'(pass_a), 32'd0);
        chk("to_cycles", 32'(cycle_count_a), 32'd64);
        chk("to_nres", 32'(res_n_a), 32'd0);
        chk("to_busy", 32'(busy_n_a), 32'd102);
        chk("to_cpu_rst", 32'(cpu_rst_a), 32'd0);

        // Halt edge coincides with the timeout limit: counts as a halt
        halt_lo = 62; halt_hi = 62;
        run_a("edge_done");
        check_good_run("edge", 64);

        // Reset mid-RUN
        halt_lo = 30; halt_hi = 30;
        clear_counts();
        pulse_a();
        for (int i = 0; i < 200; i++) begin
            if (cpu_rst_a) break;
            @(negedge clk);
        end
        chk("mrst_run_reached", 32'(cpu_rst_a), 32'd1);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrst_outs", 32'(outs_a_nonzero()), 32'd0);
        good = wr_a;
        repeat (5) @(negedge clk);
        chk("mrst_no_writes", 32'(wr_a), 32'(good));
        chk("mrst_cpu_rst", 32'(cpu_rst_a), 32'd0);
        rst = 1'b1;
        run_a("mrst_rerun_done");
        check_good_run("rerun", 32);

        // Instance B: no preload, one check, do_halt high from RUN entry for 6 cycles
        halt_lo = 0; halt_hi = 5;
        clear_counts();
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done_b) break;
            @(negedge clk);
        end
        $display("cfg_b: busy=%0d imem=%0d dmem=%0d res=%0d cycles=%0d pass=%0d",
                 busy_n_b, wr_b, dwr_b, res_n_b, cycle_count_b, pass_b);
        chk("b_done", 32'(done_b), 32'd1);
        chk("b_imem_writes", 32'(wr_b), 32'd4);
        chk("b_dmem_writes", 32'(dwr_b), 32'd0);
        chk("b_busy", 32'(busy_n_b), 32'd15);
        chk("b_nres", 32'(res_n_b), 32'd1);
        chk("b_res_idx", 32'(rb_idx), 32'd0);
        chk("b_res_ok", 32'(rb_ok), 32'd1);
        chk("b_cycles", 32'(cycle_count_b), 32'd7);
        chk("b_pass", 32'(pass_b), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
